// File: rtl/alu_mul_sequencer_pkg.sv
// Shared constants for the shift-and-add multiplier: width, ALU opcodes, FSM states.
// Latency: n/a (package). Backpressure: n/a.
// Early-exit build option lives in the top: ALU_MUL_EARLY_EXIT_EN.
package alu_mul_sequencer_pkg;

   localparam int MUL_WIDTH = 32;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_SLTU = 4'b0010,
      ALU_SLT  = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_OR   = 4'b0101,
      ALU_AND  = 4'b0110,
      ALU_SLL  = 4'b0111,
      ALU_SRL  = 4'b1000,
      ALU_SRA  = 4'b1001
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Start/result handshake plus the borrowed-ALU req/gnt port of the multiplier.
// Latency: n/a (wires only). Backpressure: i_ready on the result, i_alu_gnt on each ALU use.
// slave = multiplier side, master = pipeline/arbiter side.
interface alu_mul_sequencer_if
   import alu_mul_sequencer_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
);
   logic             i_start;
   logic [WIDTH-1:0] i_op_a;
   logic [WIDTH-1:0] i_op_b;
   logic             o_busy;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_result;
   logic             o_alu_req;
   logic             i_alu_gnt;
   logic [3:0]       o_alu_ctrl;
   logic [WIDTH-1:0] o_alu_op_0;
   logic [WIDTH-1:0] o_alu_op_1;
   logic [WIDTH-1:0] i_alu_out;

   modport slave (
      input  i_start, i_op_a, i_op_b, i_ready, i_alu_gnt, i_alu_out,
      output o_busy, o_valid, o_result, o_alu_req, o_alu_ctrl, o_alu_op_0, o_alu_op_1
   );

   modport master (
      output i_start, i_op_a, i_op_b, i_ready, i_alu_gnt, i_alu_out,
      input  o_busy, o_valid, o_result, o_alu_req, o_alu_ctrl, o_alu_op_0, o_alu_op_1
   );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add MUL (low WIDTH bits) using the shared ALU for ADDs; optional ALU_MUL_EARLY_EXIT_EN.
// Latency: WIDTH+1 cycles from start with full grant, plus one cycle per withheld grant.
// Backpressure: stalls on missing i_alu_gnt; holds result in DONE until i_ready.
module alu_mul_sequencer
   import alu_mul_sequencer_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input logic                i_clk,
   input logic                i_rst_n,
   alu_mul_sequencer_if.slave bus
);
   localparam int              CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_e           state;
   state_e           state_nxt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [CNT_W-1:0] cnt;
   logic             in_run;
   logic             early_exit;
   logic             step;
   logic             last_step;

   assign in_run = (state == S_RUN);
`ifdef ALU_MUL_EARLY_EXIT_EN
   // No set bits left: remaining iterations could not change acc.
   assign early_exit = in_run && (mplier == '0);
`else
   assign early_exit = 1'b0;
`endif
   assign step      = in_run && !early_exit && (!mplier[0] || bus.i_alu_gnt);
   assign last_step = step && (cnt == LAST_CNT);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.i_start) state_nxt = S_RUN;
         S_RUN:   if (early_exit || last_step) state_nxt = S_DONE;
         S_DONE:  if (bus.i_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (state == S_IDLE && bus.i_start) begin
         acc    <= '0;
         mcand  <= bus.i_op_a;
         mplier <= bus.i_op_b;
         cnt    <= '0;
      end else if (step) begin
         if (mplier[0]) acc <= bus.i_alu_out;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
      end
   end

   always_comb begin
      bus.o_busy     = (state != S_IDLE);
      bus.o_valid    = (state == S_DONE);
      bus.o_result   = (state == S_DONE) ? acc : '0;
      bus.o_alu_req  = in_run && mplier[0];
      bus.o_alu_ctrl = ALU_ADD;
      // Operands are quiet unless we actually hold a request on the ALU mux.
      bus.o_alu_op_0 = bus.o_alu_req ? acc   : '0;
      bus.o_alu_op_1 = bus.o_alu_req ? mcand : '0;
   end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed plus random checks of the multiplier against a plain-arithmetic product and latency model.
module tb_alu_mul_sequencer;
   import alu_mul_sequencer_pkg::*;

   localparam int W = MUL_WIDTH;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   alu_mul_sequencer_if #(.WIDTH(W)) bus ();

   alu_mul_sequencer #(.WIDTH(W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   // Shared ALU model: ADD is the only opcode the multiplier issues.
   assign bus.i_alu_out = bus.o_alu_op_0 + bus.o_alu_op_1;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Cycles from the start-accepting edge (counted as 1) until o_valid is seen.
   function automatic int exp_cycles(input logic [W-1:0] b, input int stall);
      int s;
      int msb;
      s   = (b != '0) ? stall : 0;
      msb = -1;
      for (int i = 0; i < W; i++) if (b[i]) msb = i;
`ifdef ALU_MUL_EARLY_EXIT_EN
      if (msb == W - 1) return 1 + W + s;
      return 1 + (msb + 1) + 1 + s;
`else
      return 1 + W + s + 0 * msb;
`endif
   endfunction

   // Start a multiply, grant the ALU (withholding the first grant `stall` times), run to o_valid.
   task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int stall);
      int               cycles;
      int               step_idx;
      int               stall_left;
      int               gate_bad;
      logic [W-1:0]     req_mask;
      logic [W-1:0]     exp;
      exp        = a * b;
      stall_left = stall;
      step_idx   = 0;
      gate_bad   = 0;
      req_mask   = '0;
      @(negedge clk);
      bus.i_start = 1'b1;
      bus.i_op_a  = a;
      bus.i_op_b  = b;
      @(negedge clk);
      bus.i_start = 1'b0;
      bus.i_op_a  = W'($urandom);
      bus.i_op_b  = W'($urandom);
      cycles      = 1;
      check({tag, "/busy"}, W'(bus.o_busy), W'(1));
      while (!bus.o_valid && cycles < 200) begin
         if (bus.o_alu_req) begin
            if (step_idx < W) req_mask[step_idx] = 1'b1;
            if (stall_left > 0) begin
               bus.i_alu_gnt = 1'b0;
               stall_left--;
            end else begin
               bus.i_alu_gnt = 1'b1;
               step_idx++;
            end
         end else begin
            bus.i_alu_gnt = 1'($urandom);
            step_idx++;
            if (bus.o_alu_op_0 !== '0 || bus.o_alu_op_1 !== '0) gate_bad++;
         end
         @(negedge clk);
         cycles++;
      end
      bus.i_alu_gnt = 1'b1;
      check({tag, "/valid"},   W'(bus.o_valid), W'(1));
      check({tag, "/result"},  bus.o_result, exp);
      check({tag, "/latency"}, W'(cycles), W'(exp_cycles(b, stall)));
      check({tag, "/req_bits"}, req_mask, b);
      check({tag, "/op_gate"}, W'(gate_bad), W'(0));
      check({tag, "/req_done"}, W'(bus.o_alu_req), W'(0));
   endtask

   task automatic handoff(input string tag);
      bus.i_ready = 1'b1;
      @(negedge clk);
      check({tag, "/idle_valid"}, W'(bus.o_valid), W'(0));
      check({tag, "/idle_busy"},  W'(bus.o_busy), W'(0));
   endtask

   initial begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] held;
      bus.i_start   = 1'b0;
      bus.i_op_a    = '0;
      bus.i_op_b    = '0;
      bus.i_ready   = 1'b1;
      bus.i_alu_gnt = 1'b1;

      // Reset state
      #1;
      check("rst/busy",  W'(bus.o_busy), W'(0));
      check("rst/valid", W'(bus.o_valid), W'(0));
      check("rst/req",   W'(bus.o_alu_req), W'(0));
      check("rst/ctrl",  W'(bus.o_alu_ctrl), W'(ALU_ADD));
      check("rst/res",   bus.o_result, W'(0));
      #14;
      rst_n = 1'b1;

      // Basic product and request pattern
      run_mul("7x6", W'(7), W'(6), 0);
      handoff("7x6");

      // Wrap-around and negative operands
      run_mul("ffxff", {W{1'b1}}, {W{1'b1}}, 0);
      handoff("ffxff");
      run_mul("m3x5", -W'(3), W'(5), 0);
      check("m3x5/const", bus.o_result, 32'hFFFF_FFF1);
      handoff("m3x5");

      // Withheld grant on bit 0
      run_mul("stall5", W'(32'h1234_5679), W'(32'h8000_0001), 5);
      handoff("stall5");

      // Result held while consumer stalls; starts ignored in DONE and on the handoff cycle
      bus.i_ready = 1'b0;
      run_mul("hold", W'(32'hDEAD_BEEF), W'(32'h0000_0123), 0);
      held = bus.o_result;
      for (int i = 0; i < 10; i++) begin
         bus.i_start = i[0];
         bus.i_op_a  = W'($urandom);
         bus.i_op_b  = W'($urandom);
         @(negedge clk);
         check("hold/valid",  W'(bus.o_valid), W'(1));
         check("hold/result", bus.o_result, held);
      end
      bus.i_start = 1'b1;
      bus.i_ready = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      check("hold/handoff_busy", W'(bus.o_busy), W'(0));
      @(negedge clk);
      check("hold/no_queue", W'(bus.o_busy), W'(0));

      // Asynchronous reset in the middle of RUN
      @(negedge clk);
      bus.i_start = 1'b1;
      bus.i_op_a  = W'(32'h0000_0055);
      bus.i_op_b  = W'(32'hF000_0001);
      @(negedge clk);
      bus.i_start = 1'b0;
      repeat (12) @(negedge clk);
      check("midrun/busy", W'(bus.o_busy), W'(1));
      #2 rst_n = 1'b0;
      #1;
      check("midrun_rst/busy",  W'(bus.o_busy), W'(0));
      check("midrun_rst/valid", W'(bus.o_valid), W'(0));
      check("midrun_rst/req",   W'(bus.o_alu_req), W'(0));
      check("midrun_rst/res",   bus.o_result, W'(0));
      check("midrun_rst/op0",   bus.o_alu_op_0, W'(0));
      check("midrun_rst/op1",   bus.o_alu_op_1, W'(0));
      check("midrun_rst/ctrl",  W'(bus.o_alu_ctrl), W'(ALU_ADD));
      @(negedge clk);
      rst_n = 1'b1;
      run_mul("3x4", W'(3), W'(4), 0);
      handoff("3x4");

      // Small multipliers: early exit shortens these when enabled
      run_mul("b0", W'(32'h0BAD_F00D), W'(0), 0);
      handoff("b0");
      run_mul("b1", W'(32'h0BAD_F00D), W'(1), 0);
      handoff("b1");

      // Random operands, random first-grant stall
      for (int n = 0; n < 10; n++) begin
         a = W'($urandom);
         b = W'($urandom);
         if (n % 3 == 0) b = b >> $urandom_range(W - 1, 16);
         run_mul("rand", a, b, int'($urandom_range(3, 0)));
         handoff("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "simulation did not complete");
   end

endmodule
